// File: rtl/fantasticfft_pkg.sv
// Shared types and constants for the FFT8 frame scheduler.
package fantasticfft_pkg;

    localparam int unsigned FFT_POINTS = 8;

    typedef logic signed [15:0] q88_t;

    typedef struct packed {
        q88_t re;
        q88_t im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fantasticfft_frame_collector.sv
// Packs the serial sample stream into eight-sample frames for the FFT8 core.
module fantasticfft_frame_collector
    import fantasticfft_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         issue,
    output logic                         in_ready,
    output logic                         frame_full,
    output logic [FFT_POINTS*DATA_W-1:0] frame
);

    localparam int unsigned IW = $clog2(FFT_POINTS);

    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] sbuf [FFT_POINTS];

    assign in_ready = !frame_full;

    // A full frame blocks acceptance, so issue and accept never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= '0;
            frame_full <= 1'b0;
        end else begin
            if (issue)
                frame_full <= 1'b0;
            if (in_valid && in_ready) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == IW'(FFT_POINTS - 1))
                    frame_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            sbuf[wr_idx] <= in_data;
    end

    always_comb begin
        frame = '0;
        for (int unsigned k = 0; k < FFT_POINTS; k++)
            frame[k*DATA_W +: DATA_W] = sbuf[k];
    end

endmodule

// File: rtl/fantasticfft_fft8_sched.sv
// FFT8 frame scheduler: issues collected frames, waits for the result, streams bins out.
module fantasticfft_fft8_sched
    import fantasticfft_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 10,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic [FFT_POINTS*DATA_W-1:0] fft_x,
    output logic                         fft_is_valid,
    input  logic [FFT_POINTS*DATA_W-1:0] fft_y,
    input  logic [FFT_POINTS*DATA_W-1:0] fft_yi,
    input  logic                         fft_result_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_re,
    output logic [DATA_W-1:0]            out_im,
    output logic [2:0]                   out_bin,
    output logic                         out_last,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [CNT_W-1:0]             frame_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                         state;
    logic [TW-1:0]                  timer;
    logic [2:0]                     rd_idx;
    logic [DATA_W-1:0]              res_re [FFT_POINTS];
    logic [DATA_W-1:0]              res_im [FFT_POINTS];
    logic [FFT_POINTS*DATA_W-1:0]   frame;
    logic                           frame_full;
    logic                           issue;
    logic                           capture;

    assign issue   = (state == ST_IDLE) && frame_full;
    assign capture = (state == ST_WAIT) && !fft_is_valid && fft_result_valid;

    fantasticfft_frame_collector #(
        .DATA_W (DATA_W)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .issue      (issue),
        .in_ready   (in_ready),
        .frame_full (frame_full),
        .frame      (frame)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            fft_is_valid <= 1'b0;
            fft_x        <= '0;
            timer        <= '0;
            rd_idx       <= '0;
            timeout_err  <= 1'b0;
            frame_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_full) begin
                        fft_x        <= frame;
                        fft_is_valid <= 1'b1;
                        timer        <= '0;
                        state        <= ST_WAIT;
                        busy         <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The issue cycle itself never counts as a result or a wait cycle.
                    if (fft_is_valid) begin
                        fft_is_valid <= 1'b0;
                    end else if (fft_result_valid) begin
                        rd_idx <= '0;
                        state  <= ST_DRAIN;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        rd_idx <= rd_idx + 3'd1;
                        if (rd_idx == 3'd7) begin
                            frame_count <= frame_count + 1'b1;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned k = 0; k < FFT_POINTS; k++) begin
                res_re[k] <= fft_y[k*DATA_W +: DATA_W];
                res_im[k] <= fft_yi[k*DATA_W +: DATA_W];
            end
        end
    end

    // Bin outputs are gated so reset and idle present zeros regardless of buffer contents.
    assign out_valid = (state == ST_DRAIN);
    assign out_re    = out_valid ? res_re[rd_idx] : '0;
    assign out_im    = out_valid ? res_im[rd_idx] : '0;
    assign out_bin   = rd_idx;
    assign out_last  = out_valid && (rd_idx == 3'd7);

endmodule

// File: tb/tb_fantasticfft_fft8_sched.sv
// Scoreboard bench for the FFT8 scheduler with a behavioural FFT8 core model.
module tb_fantasticfft_fft8_sched;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 10;
    localparam int CNT_W   = 8;
    localparam real PI     = 3.14159265358979;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  bin;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;
    logic [127:0]       fft_x;
    logic               fft_is_valid;
    logic [127:0]       fft_y;
    logic [127:0]       fft_yi;
    logic               fft_result_valid;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_re;
    logic [15:0]        out_im;
    logic [2:0]         out_bin;
    logic               out_last;
    logic               busy;
    logic               timeout_err;
    logic [CNT_W-1:0]   frame_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] samp_q[$];
    exp_t        exp_q[$];
    logic [15:0] obs_re [8];
    logic [15:0] obs_im [8];
    bit          model_en   = 1;
    bit          spur_issue = 0;

    fantasticfft_fft8_sched #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .fft_x            (fft_x),
        .fft_is_valid     (fft_is_valid),
        .fft_y            (fft_y),
        .fft_yi           (fft_yi),
        .fft_result_valid (fft_result_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_re           (out_re),
        .out_im           (out_im),
        .out_bin          (out_bin),
        .out_last         (out_last),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .frame_count      (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no-finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_q(input real v);
        int i;
        if (v >= 0.0) i = $rtoi(v * 256.0 + 0.5);
        else          i = -$rtoi(-v * 256.0 + 0.5);
        return i[15:0];
    endfunction

    // Behavioural FFT8: checks the issued lanes, then returns a DFT of the bench's own samples.
    initial begin
        logic [15:0] fr [8];
        logic [15:0] yr [8];
        logic [15:0] yi [8];
        real xr [8];
        real sre, sim, ang;
        exp_t e;
        fft_result_valid = 1'b0;
        fft_y  = '0;
        fft_yi = '0;
        forever begin
            @(negedge clk);
            if (!rst && fft_is_valid) begin
                for (int k = 0; k < 8; k++) begin
                    if (samp_q.size() == 0) begin
                        check_eq("fft_x_unexpected", 1, 0);
                        fr[k] = '0;
                    end else begin
                        fr[k] = samp_q.pop_front();
                        check_eq($sformatf("fft_x_lane%0d", k), fft_x[k*16 +: 16], fr[k]);
                    end
                end
                if (spur_issue) begin
                    fft_y  = {8{16'h7FFF}};
                    fft_yi = {8{16'h7FFF}};
                    fft_result_valid = 1'b1;
                    @(posedge clk); #1;
                    fft_result_valid = 1'b0;
                end
                @(negedge clk);
                check_eq("issue_pulse_width", fft_is_valid, 0);
                if (model_en) begin
                    for (int n = 0; n < 8; n++) xr[n] = $itor($signed(fr[n])) / 256.0;
                    for (int k = 0; k < 8; k++) begin
                        sre = 0.0;
                        sim = 0.0;
                        for (int n = 0; n < 8; n++) begin
                            ang = 2.0 * PI * $itor(k * n) / 8.0;
                            sre = sre + xr[n] * $cos(ang);
                            sim = sim - xr[n] * $sin(ang);
                        end
                        yr[k] = to_q(sre);
                        yi[k] = to_q(sim);
                    end
                    repeat (2) @(posedge clk);
                    #1;
                    for (int k = 0; k < 8; k++) begin
                        fft_y[k*16 +: 16]  = yr[k];
                        fft_yi[k*16 +: 16] = yi[k];
                        e.re  = yr[k];
                        e.im  = yi[k];
                        e.bin = 3'(k);
                        exp_q.push_back(e);
                    end
                    fft_result_valid = 1'b1;
                    @(posedge clk); #1;
                    fft_result_valid = 1'b0;
                end
            end
        end
    end

    // Output monitor: every transferred bin must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_bin", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_re", out_re, e.re);
                    check_eq("out_im", out_im, e.im);
                    check_eq("out_bin", out_bin, e.bin);
                    check_eq("out_last", out_last, (e.bin == 3'd7));
                    obs_re[out_bin] = out_re;
                    obs_im[out_bin] = out_im;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        samp_q.delete();
        exp_q.delete();
    endtask

    task automatic send_sample(input logic [15:0] d);
        bit acc;
        int budget;
        in_data  = d;
        in_valid = 1'b1;
        acc      = 1'b0;
        budget   = 0;
        while (!acc && budget < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            budget++;
        end
        if (acc) samp_q.push_back(d);
        else     check_eq("send_timeout", 1, 0);
    endtask

    task automatic send_frame(input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < 8; i++) send_sample(base + 16'(i) * step);
    endtask

    task automatic wait_count(input string tag, input int target, input int budget);
        int n = 0;
        while (frame_count != CNT_W'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, frame_count, target);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_fft_is_valid", fft_is_valid, 0);
        check_eq("rst_fft_x", fft_x, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_re", out_re, 0);
        check_eq("rst_out_im", out_im, 0);
        check_eq("rst_out_bin", out_bin, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_frame_count", frame_count, 0);

        // Nominal frame 1.0 .. 8.0
        @(posedge clk); #1;
        send_frame(16'h0100, 16'h0100);
        in_valid = 1'b0;
        wait_count("nominal_count", 1, 100);
        check_eq("nominal_bin0_re", obs_re[0], 16'h2400);
        check_eq("nominal_bin0_im", obs_im[0], 16'h0000);
        check_eq("nominal_bin4_re", obs_re[4], 16'hFC00);
        check_eq("nominal_bin4_im", obs_im[4], 16'h0000);
        check_eq("nominal_idle_busy", busy, 0);

        // Backpressure at bin 2 while the next frame streams in
        do_reset();
        send_frame(16'h0200, 16'h0080);
        fork
            begin
                send_frame(16'hFF00, 16'h0020);
                in_valid = 1'b0;
                @(negedge clk);
                check_eq("bp_in_ready_full", in_ready, 0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(out_valid && out_ready && out_bin == 3'd1) && n < 100);
                check_eq("bp_reach_bin1", out_bin, 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_hold_valid", out_valid, 1);
                    check_eq("bp_hold_bin", out_bin, 2);
                    check_eq("bp_hold_re", out_re, (exp_q.size() > 0) ? exp_q[0].re : 16'hxxxx);
                    check_eq("bp_hold_im", out_im, (exp_q.size() > 0) ? exp_q[0].im : 16'hxxxx);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_ready && out_last) && n < 100);
        check_eq("bp_last_seen", out_last, 1);
        @(negedge clk);
        check_eq("bp_idle_gap_issue", fft_is_valid, 0);
        check_eq("bp_idle_gap_busy", busy, 0);
        @(negedge clk);
        check_eq("bp_b2b_issue", fft_is_valid, 1);
        wait_count("bp_count", 2, 100);

        // Spurious result strobes: in IDLE, then in the issue cycle
        @(posedge clk); #1;
        fft_y  = {8{16'h7FFF}};
        fft_yi = {8{16'h7FFF}};
        fft_result_valid = 1'b1;
        @(posedge clk); #1;
        fft_result_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("spur_idle_no_drain", {busy, out_valid}, 0);
        end
        spur_issue = 1'b1;
        @(posedge clk); #1;
        send_frame(16'h0080, 16'h0040);
        in_valid = 1'b0;
        wait_count("spur_count", 3, 100);
        spur_issue = 1'b0;

        // Timeout: core never answers
        model_en = 1'b0;
        @(posedge clk); #1;
        send_frame(16'h0300, 16'h0010);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fft_is_valid && n < 50);
        check_eq("to_issued", fft_is_valid, 1);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_err", timeout_err, 1);
        check_eq("to_latency_in_range", (n >= TIMEOUT && n <= TIMEOUT + 2), 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_out_valid", out_valid, 0);
        check_eq("to_count", frame_count, 3);
        model_en = 1'b1;

        // Reset mid-drain at bin 4
        @(posedge clk); #1;
        send_frame(16'h0100, 16'h0100);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_bin == 3'd4) && n < 100);
        check_eq("rd_reach_bin4", out_bin, 4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        samp_q.delete();
        exp_q.delete();
        @(negedge clk);
        check_eq("rd_out_valid", out_valid, 0);
        check_eq("rd_timeout_err", timeout_err, 0);
        check_eq("rd_count", frame_count, 0);
        check_eq("rd_busy", busy, 0);

        // Reset mid-fill, then a fresh frame
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_sample(16'h0500 + 16'(i));
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check_eq("rf_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send_frame(16'h0A00, 16'h0100);
        in_valid = 1'b0;
        wait_count("rf_count", 1, 100);
        check_eq("rf_queue_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fantasticfft_fft8_sched.md
Name: fantasticfft_fft8_sched

Overview:
Frame scheduler and sequencer for the FFT8 datapath. It accepts a serial stream of Q8.8 real samples and packs them eight at a time into a frame buffer. It issues each frame to the FFT8 core with a one-cycle isValid pulse, waits for resultValid with a timeout, captures the complex result, and serializes the eight bins out on a valid/ready stream. It sits between the sample source and the FFT8 core, and the next frame is collected while the current one is in flight.

Parameters:
DATA_W, 16, sample/result word width; Q8.8 two's complement (8 integer, 8 fraction bits)
TIMEOUT_CYCLES, 10, maximum cycles to wait for fft_result_valid after issue
CNT_W, 8, width of frame_count (wraps)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  scheduler can accept a sample
in_data  in  DATA_W  Q8.8 real sample
fft_x  out  8*DATA_W  frame to FFT8; lane k at bits [k*DATA_W +: DATA_W]
fft_is_valid  out  1  one-cycle issue pulse (drives isValid)
fft_y  in  8*DATA_W  FFT8 real outputs, same lane packing
fft_yi  in  8*DATA_W  FFT8 imaginary outputs
fft_result_valid  in  1  FFT8 resultValid
out_valid  out  1  result bin valid
out_ready  in  1  downstream accepts bin
out_re  out  DATA_W  bin real part
out_im  out  DATA_W  bin imaginary part
out_bin  out  3  bin index 0..7
out_last  out  1  high with bin 7
busy  out  1  issue FSM not in IDLE
timeout_err  out  1  sticky; set on any FFT timeout
frame_count  out  CNT_W  frames fully drained; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst sampled high):
  - Outputs: in_ready=1, fft_is_valid=0, fft_x=0, out_valid=0, out_re=0, out_im=0, out_bin=0, out_last=0, busy=0, timeout_err=0, frame_count=0.
  - Internal state: wr_idx=0, frame_full=0, FSM=IDLE. Any partial or in-flight frame is discarded.
- Collector:
  - in_ready = !frame_full.
  - On in_valid & in_ready: buf[wr_idx] <= in_data, wr_idx increments.
  - When the sample accepted has wr_idx==7: frame_full <= 1 and wr_idx <= 0.
  - Collection proceeds independently of the issue FSM state.
- Issue FSM, states IDLE, WAIT, DRAIN:
  - IDLE:
    - If frame_full: at the edge, fft_x <= buf, fft_is_valid <= 1, frame_full <= 0, timer <= 0, go to WAIT.
    - Latency: 8th sample accepted at edge E; fft_is_valid is high during the cycle after edge E+1.
  - WAIT:
    - fft_is_valid is high only in the first WAIT cycle, then 0. fft_x holds until leaving WAIT.
    - fft_result_valid is ignored in the cycle fft_is_valid=1.
    - Otherwise, if fft_result_valid=1: capture fft_y/fft_yi into the result buffer, rd_idx <= 0, go to DRAIN.
    - Otherwise timer increments. When timer reaches TIMEOUT_CYCLES: timeout_err <= 1, drop the frame, go to IDLE.
  - DRAIN:
    - out_valid=1, out_re/out_im = result[rd_idx], out_bin=rd_idx, out_last=(rd_idx==7).
    - On out_ready: advance rd_idx. The transfer on bin 7 increments frame_count and returns to IDLE.
    - Outputs are held stable while out_ready=0.
- fft_result_valid outside WAIT (IDLE/DRAIN) is ignored and does not corrupt the result buffer.
- Frame ordering:
  - A frame that becomes full during WAIT or DRAIN is issued from the first IDLE cycle.
  - Back-to-back frames add exactly one IDLE cycle between the last drained bin and the next issue.
- Data is passed through unmodified. No rounding or saturation in this block; Q8.8 arithmetic belongs to FFT8.
- busy = (FSM != IDLE), registered together with the state.

Decomposition:
- Shared package fantasticfft_pkg holds:
  - the fixed-point sample typedef (16-bit, 8.8) and the complex bin struct {re, im}
  - FFT_POINTS=8
  - the FSM state enum
- Sub-module fantasticfft_frame_collector: wr_idx counter, sample buffer, frame_full flag, in_ready. The FSM and result buffer live in the top.

Test Plan:
- Nominal frame:
  - Stimulus: stream 0x0100..0x0800 (1.0..8.0) with in_valid held high; behavioural FFT8 model returns result 3 cycles after isValid; out_ready=1.
  - Required: one fft_is_valid pulse with lanes 0x0100..0x0800; out bin0 re=0x2400 (36.0), im=0; bin4 re=0xFC00 (-4.0), im=0; bins 0..7 in order; out_last only on bin 7; frame_count=1.
- Backpressure:
  - Stimulus: drop out_ready for 5 cycles at bin 2 while a second frame streams in.
  - Required: bin 2 values held stable; in_ready=0 after the 8th second-frame sample; second frame issued one cycle after bin 7 drains; frame_count=2.
- Timeout:
  - Stimulus: FFT8 model never asserts resultValid.
  - Required: timeout_err=1 after TIMEOUT_CYCLES; FSM back to IDLE, busy=0; no out_valid; frame_count unchanged.
- Spurious result:
  - Stimulus: pulse fft_result_valid in IDLE, and in the issue cycle with fft_y all 0x7FFF.
  - Required: no DRAIN entry; subsequent real result is drained correctly.
- Reset mid-fill:
  - Stimulus: rst after 5 samples; then 8 new samples 0x0A00..0x1100.
  - Required: in_ready=1 after reset; issued fft_x lanes equal exactly the new 8 samples.
- Reset mid-drain:
  - Stimulus: rst at bin 4.
  - Required: out_valid=0, timeout_err=0, frame_count=0 the next cycle.
